// File: rtl/cherry_loop_pkg.sv
// Shared types for the loop-stack / APU engine.
// Command opcodes, loop-stack entry layout, superscalar width helper.
package cherry_loop_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_END   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_t;

  // Fields are sized for the widest supported build; narrower
  // configurations use the low bits.
  typedef struct packed {
    logic [31:0] value;
    logic [31:0] total;
    logic [15:0] jump;
    logic        indep;
    logic [7:0]  name;
  } loop_entry_t;

  function automatic int ss_width(input int log_ss);
    return 1 << log_ss;
  endfunction

endpackage

// File: rtl/apu_lane.sv
// One APU update lane: pick the coefficient for the loop name,
// then addr + di * coef, everything modulo 2^ADDR_W.
module apu_lane #(
  parameter int LOG_LOOP_CNT = 3,
  parameter int ADDR_W       = 18
) (
  input  logic [(2**LOG_LOOP_CNT)*ADDR_W-1:0] coefs,
  input  logic [LOG_LOOP_CNT-1:0]             name,
  input  logic [ADDR_W-1:0]                   di,
  input  logic [ADDR_W-1:0]                   addr_in,
  output logic [ADDR_W-1:0]                   addr_next
);

  logic [ADDR_W-1:0] coef;
  logic [ADDR_W-1:0] prod;

  assign coef      = coefs[name*ADDR_W +: ADDR_W];
  assign prod      = di * coef;
  assign addr_next = addr_in + prod;

endmodule

// File: rtl/loop_apu_engine.sv
// Loop stack plus APU address registers, updated APU_LANES at a time.
// Optional macro APU_BOUNDS_CHECK_EN enables sticky per-APU bound flags.
module loop_apu_engine #(
  parameter int LOG_LOOP_CNT = 3,
  parameter int LOG_APU_CNT  = 3,
  parameter int APU_LANES    = 2,
  parameter int ADDR_W       = 18,
  parameter int ITER_W       = 18,
  parameter int JUMP_W       = 6,
  parameter int LOG_SS_W     = 3,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cfg_we,
  input  logic [LOG_APU_CNT-1:0]                 cfg_apu_idx,
  input  logic [(2**LOG_LOOP_CNT)*ADDR_W-1:0]    cfg_coef,
  input  logic [ADDR_W-1:0]                      cfg_base,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [1:0]                             cmd_op,
  input  logic [LOG_LOOP_CNT-1:0]                cmd_name,
  input  logic [ITER_W-1:0]                      cmd_iters,
  input  logic [JUMP_W-1:0]                      cmd_jump,
  input  logic                                   cmd_indep,
  output logic                                   rsp_valid,
  output logic [JUMP_W-1:0]                      rsp_jump,
  output logic                                   rsp_done,
  output logic [LOG_SS_W:0]                      copy_count,
  output logic [LOG_LOOP_CNT:0]                  depth,
  output logic [(2**LOG_APU_CNT)*ADDR_W-1:0]     addr_out,
  output logic [(2**LOG_APU_CNT)*ADDR_W-1:0]     daddr_out,
  output logic                                   err_overflow,
  output logic                                   err_underflow,
  output logic [(2**LOG_APU_CNT)-1:0]            err_oob
);
  import cherry_loop_pkg::*;

  localparam int LOOP_CNT = 1 << LOG_LOOP_CNT;
  localparam int APU_CNT  = 1 << LOG_APU_CNT;
  localparam int SW       = ss_width(LOG_SS_W);
  localparam int APPLY_N  = APU_CNT / APU_LANES;
  localparam logic [LOG_LOOP_CNT:0] FULL = (LOG_LOOP_CNT+1)'(LOOP_CNT);
  localparam logic [ITER_W-1:0] SW_I = ITER_W'(SW);
  localparam logic [LOG_APU_CNT-1:0] LAST = LOG_APU_CNT'(APPLY_N - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_EVAL, S_APPLY, S_RESP
  } state_t;

  state_t state;
  cmd_op_t op_q;
  logic [LOG_LOOP_CNT-1:0] name_q, upd_name;
  logic [ITER_W-1:0] iters_q;
  logic [JUMP_W-1:0] jump_q;
  logic indep_q;
  logic [LOG_LOOP_CNT:0] depth_r;
  logic [ADDR_W-1:0] di;
  logic [LOG_APU_CNT-1:0] apply_cnt;

  loop_entry_t stack [LOOP_CNT];
  logic [LOOP_CNT*ADDR_W-1:0] formula [APU_CNT];
  logic [ADDR_W-1:0] addr [APU_CNT];

  loop_entry_t top;
  logic [LOG_LOOP_CNT:0] dm1;
  logic [LOG_LOOP_CNT-1:0] top_idx, top_name;
  logic [ITER_W-1:0] rem, step;
  logic unused_top;

  logic [LOG_APU_CNT-1:0] lane_idx [APU_LANES];
  logic [ADDR_W-1:0] lane_out [APU_LANES];

  assign dm1        = depth_r - 1'b1;
  assign top_idx    = dm1[LOG_LOOP_CNT-1:0];
  assign top        = stack[top_idx];
  assign top_name   = top.name[LOG_LOOP_CNT-1:0];
  assign rem        = top.total[ITER_W-1:0] - top.value[ITER_W-1:0];
  assign unused_top = ^top;
  assign depth      = depth_r;
  assign cmd_ready  = (state == S_IDLE) && !cfg_we;

  // Step size of the innermost loop and its queue copy count.
  always_comb begin
    step = ITER_W'(1);
    if (top.indep) step = (rem < SW_I) ? rem : SW_I;
    copy_count = (LOG_SS_W+1)'(1);
    if (depth_r != '0) copy_count = (LOG_SS_W+1)'(step);
  end

  // Flatten address registers and innermost-loop deltas.
  always_comb begin
    addr_out  = '0;
    daddr_out = '0;
    for (int k = 0; k < APU_CNT; k++) begin
      addr_out[k*ADDR_W +: ADDR_W] = addr[k];
      if (depth_r != '0)
        daddr_out[k*ADDR_W +: ADDR_W] =
          formula[k][top_name*ADDR_W +: ADDR_W];
    end
  end

  for (genvar l = 0; l < APU_LANES; l++) begin : g_lane
    assign lane_idx[l] =
      LOG_APU_CNT'(int'(apply_cnt) * APU_LANES + l);
    apu_lane #(
      .LOG_LOOP_CNT(LOG_LOOP_CNT),
      .ADDR_W(ADDR_W)
    ) u_lane (
      .coefs(formula[lane_idx[l]]),
      .name(upd_name),
      .di(di),
      .addr_in(addr[lane_idx[l]]),
      .addr_next(lane_out[l])
    );
  end

  // Command FSM: evaluate the stack, sweep the APUs, respond.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      op_q          <= OP_NOP;
      name_q        <= '0;
      iters_q       <= '0;
      jump_q        <= '0;
      indep_q       <= 1'b0;
      upd_name      <= '0;
      depth_r       <= '0;
      di            <= '0;
      apply_cnt     <= '0;
      rsp_valid     <= 1'b0;
      rsp_jump      <= '0;
      rsp_done      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < LOOP_CNT; i++) stack[i] <= '0;
      for (int k = 0; k < APU_CNT; k++) begin
        formula[k] <= '0;
        addr[k]    <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_we) begin
            formula[cfg_apu_idx] <= cfg_coef;
            addr[cfg_apu_idx]    <= cfg_base;
          end else if (cmd_valid) begin
            op_q    <= cmd_op_t'(cmd_op);
            name_q  <= cmd_name;
            iters_q <= cmd_iters;
            jump_q  <= cmd_jump;
            indep_q <= cmd_indep;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          di        <= '0;
          rsp_jump  <= '0;
          rsp_done  <= 1'b0;
          upd_name  <= top_name;
          apply_cnt <= '0;
          state     <= S_APPLY;
          unique case (op_q)
            OP_START: begin
              if (depth_r < FULL) begin
                stack[depth_r[LOG_LOOP_CNT-1:0]] <= '{
                  value: 32'd0,
                  total: (iters_q == '0) ? 32'd1 : 32'(iters_q),
                  jump:  16'(jump_q),
                  indep: indep_q,
                  name:  8'(name_q)
                };
                depth_r <= depth_r + 1'b1;
                if (iters_q == '0) err_underflow <= 1'b1;
              end else begin
                err_overflow <= 1'b1;
              end
            end
            OP_END: begin
              if (depth_r == '0) begin
                err_underflow <= 1'b1;
              end else if (rem > step) begin
                stack[top_idx].value <=
                  32'(top.value[ITER_W-1:0] + step);
                di       <= ADDR_W'(step);
                rsp_jump <= top.jump[JUMP_W-1:0];
              end else begin
                di <= ADDR_W'(0) - ADDR_W'(top.value[ITER_W-1:0]);
                depth_r  <= depth_r - 1'b1;
                rsp_done <= 1'b1;
              end
            end
            OP_CLEAR: begin
              depth_r       <= '0;
              err_overflow  <= 1'b0;
              err_underflow <= 1'b0;
            end
            default: ;
          endcase
        end
        S_APPLY: begin
          for (int l = 0; l < APU_LANES; l++)
            addr[lane_idx[l]] <= lane_out[l];
          apply_cnt <= apply_cnt + 1'b1;
          if (apply_cnt == LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef APU_BOUNDS_CHECK_EN
  // Sticky out-of-bounds flag per APU, checked on every APPLY write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_oob <= '0;
    end else if (state == S_EVAL && op_q == OP_CLEAR) begin
      err_oob <= '0;
    end else if (state == S_APPLY) begin
      for (int l = 0; l < APU_LANES; l++)
        if (lane_out[l] > ADDR_LIMIT) err_oob[lane_idx[l]] <= 1'b1;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
  assign err_oob = '0;
`endif

endmodule
